spi_reg_bridge: RTL
===================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on spi_sck, spi_ss_n and spi_mosi; legal range 2-3.
REQ-002 Parameter ADDR_W, default 7: register address width.
REQ-003 clk  in  1  single system clock; all state is clocked on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 spi_sck  in  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-006 spi_ss_n  in  1  SPI select, active-low; frames one transaction.
REQ-007 spi_mosi  in  1  host-to-bridge serial data.
REQ-008 spi_miso  out  1  bridge-to-host serial data; 1'bz while spi_ss_n is high (synchronized).
REQ-009 reg_addr  out  ADDR_W  register address presented with every strobe.
REQ-010 reg_cs  out  1  one-clk register select strobe.
REQ-011 reg_we  out  1  write qualifier; valid only while reg_cs=1.
REQ-012 reg_wdata  out  8  write data; valid while reg_cs=1 and reg_we=1.
REQ-013 reg_rdata  in  8  shared register read bus; sampled in the cycle reg_cs=1 and reg_we=0.

Function
REQ-014 Frame format: byte 0 = command {rw, addr[6:0]}, where rw=1 is a write and rw=0 is a read; bytes 1..N = data.
REQ-015 Bit sampling: spi_mosi is sampled on the synchronized rising edge of spi_sck; the bit counter (0-7) advances on each rising edge.
REQ-016 FSM states: IDLE, CMD, WDATA, RDATA.
  - IDLE->CMD on the ss_n falling edge.
  - CMD->WDATA or CMD->RDATA on the 8th rising edge, according to rw.
  - Any state->IDLE when synchronized ss_n is high.
REQ-017 Write, per completed data byte: reg_cs=1, reg_we=1, reg_wdata=byte, reg_addr=current address, for exactly one clk.
  - The strobe occurs on the cycle after the 8th rising edge is detected.
  - The address then increments.
REQ-018 Read at command completion: one clk later, reg_cs=1 and reg_we=0 with reg_addr=addr.
  - reg_rdata is captured into the tx shift register in that same cycle.
  - spi_miso immediately shows tx[7].
REQ-019 Read burst: after each completed RDATA byte, the address increments and the next read strobe and load follow with the REQ-018 timing.
REQ-020 MISO shifting: tx shifts on synchronized falling sck edges, except the falling edge that closes a byte (bit counter = 0), which is ignored.
REQ-021 MISO outputs 0 throughout the command byte and throughout WDATA.
REQ-022 Address arithmetic: increment wraps modulo 2^ADDR_W (0x7F -> 0x00); no error is flagged.
REQ-023 Deselect mid-byte (ss_n high with bit counter != 0): the partial byte is discarded, no strobe is issued, and the state returns to IDLE.
REQ-024 A strobe already in flight completes.
REQ-025 Strobes are never issued while in IDLE.
REQ-026 reg_cs is never asserted on two consecutive clocks.
REQ-027 Timing requirement on the host: f_sck <= f_clk/8, and the ss_n-to-first-sck setup is >= SYNC_STAGES+2 clk.

Reset
REQ-028 While rst_n=0: state=IDLE, bit counter=0, address=0, tx=0, reg_cs=0, reg_we=0, reg_wdata=0, reg_addr=0, spi_miso=z.
REQ-029 The synchronizer flops reset to their inactive values: sck=0, ss_n=1, mosi=0.
REQ-030 Reset asserted mid-transaction aborts the transaction with no strobe.
REQ-031 After reset release, the bridge waits for a fresh ss_n falling edge; an ss_n already low at release is ignored until it goes high and then low again.

Structure
REQ-032 A shared package holds the FSM state enum, the rw bit position (7) and the SYNC_STAGES default.
REQ-033 One sub-module, spi_sync_edge, provides a SYNC_STAGES flop chain with rise/fall pulse outputs; it is instantiated for sck and ss_n.
REQ-034 spi_mosi uses the same chain depth without edge detection, keeping data aligned with the sck edges.

Verification
REQ-035 Single write: frame 0x85,0x3C -> one strobe with reg_addr=0x05, reg_we=1, reg_wdata=0x3C; no further strobes.
REQ-036 Single read: the bench models register 0x12 = 0xA7; frame 0x12,0x00 -> one read strobe at 0x12, and MISO returns 0xA7 during byte 1.
REQ-037 Burst wrap: write frame 0xFF,0x11,0x22 -> strobes at addr 0x7F (0x11), then 0x00 (0x22).
REQ-038 Burst read: registers 0x20=0x01 and 0x21=0x02; frame 0x20,x,x -> MISO returns 0x01 then 0x02, with a read strobe at 0x22 (prefetch) and no write strobes.
REQ-039 Abort: ss_n raised after 5 bits of the data byte in frame 0x81 -> no strobe; the next frame 0x81,0x55 writes 0x55 to address 0x01.
REQ-040 Reset mid-frame: rst_n pulsed low after the command byte -> all outputs at reset values and no strobe; the first frame after release behaves as in REQ-035.

Source files
------------

// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI-to-register bridge.
// Holds the FSM state encoding, command-byte layout and synchronizer default.
package spi_reg_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RDATA = 2'd3
   } state_t;

   localparam int RW_BIT          = 7;
   localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// STAGES-deep synchronizer with registered previous value for single-clk edge pulses.
// Latency: STAGES clk to sync, edge pulses in the same cycle; no backpressure.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign sync = chain[STAGES-1];
   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave turning {rw,addr} + data frames into one-clk register strobes.
// Latency: strobe 1 clk after the synchronized 8th sck rise; host paces the link, no backpressure.
module spi_reg_bridge
   import spi_reg_bridge_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int ADDR_W      = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sck,
   input  logic              spi_ss_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] reg_addr,
   output logic              reg_cs,
   output logic              reg_we,
   output logic [7:0]        reg_wdata,
   input  logic [7:0]        reg_rdata
);

   logic sck_sync, sck_rise, sck_fall;
   logic ss_sync, ss_rise, ss_fall;
   logic [SYNC_STAGES-1:0] mosi_chain;
   logic mosi_sync;
   logic unused_edges;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .rst_n(rst_n), .din(spi_sck),
      .sync(sck_sync), .rise(sck_rise), .fall(sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
      .clk(clk), .rst_n(rst_n), .din(spi_ss_n),
      .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
   );

   assign unused_edges = ^{sck_sync, ss_rise};

   // Same depth as the sck chain so each sampled bit lines up with its rise pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi_chain <= '0;
      else        mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
   end
   assign mosi_sync = mosi_chain[SYNC_STAGES-1];

   state_t            state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [6:0]        rx_q, rx_d;
   logic [7:0]        tx_q, tx_d;
   logic              armed_q, armed_d;
   logic [SYNC_STAGES:0] flush_q;
   logic              cs_q, cs_d, we_q, we_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [7:0]        rx_byte;
   logic [ADDR_W-1:0] cmd_addr;
   logic              byte_done;

   assign rx_byte   = {rx_q, mosi_sync};
   assign cmd_addr  = ADDR_W'(rx_byte[RW_BIT-1:0]);
   assign byte_done = (state_q != ST_IDLE) && !ss_sync && sck_rise && (bit_cnt_q == 3'd7);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      addr_d    = addr_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      cs_d      = 1'b0;
      we_d      = 1'b0;
      wdata_d   = wdata_q;
      raddr_d   = raddr_q;
      // Arm only once the reset values have flushed out and ss_n is seen high.
      armed_d   = armed_q | (flush_q[SYNC_STAGES] & ss_sync);

      if (cs_q && !we_q) tx_d = reg_rdata;

      if (state_q == ST_IDLE) begin
         bit_cnt_d = 3'd0;
         tx_d      = 8'h00;
         if (ss_fall && armed_q) state_d = ST_CMD;
      end else if (ss_sync) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         tx_d      = 8'h00;
      end else begin
         if (sck_rise) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
         // The fall closing a byte is skipped so a freshly loaded tx[7] stays on the line.
         if (state_q == ST_RDATA && sck_fall && bit_cnt_q != 3'd0)
            tx_d = {tx_q[6:0], 1'b0};
         if (byte_done) begin
            case (state_q)
               ST_CMD: begin
                  if (rx_byte[RW_BIT]) begin
                     state_d = ST_WDATA;
                     addr_d  = cmd_addr;
                  end else begin
                     state_d = ST_RDATA;
                     cs_d    = 1'b1;
                     raddr_d = cmd_addr;
                     addr_d  = cmd_addr + ADDR_W'(1);
                  end
               end
               ST_WDATA: begin
                  cs_d    = 1'b1;
                  we_d    = 1'b1;
                  wdata_d = rx_byte;
                  raddr_d = addr_q;
                  addr_d  = addr_q + ADDR_W'(1);
               end
               default: begin
                  cs_d    = 1'b1;
                  raddr_d = addr_q;
                  addr_d  = addr_q + ADDR_W'(1);
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 3'd0;
         addr_q    <= '0;
         rx_q      <= '0;
         tx_q      <= 8'h00;
         armed_q   <= 1'b0;
         flush_q   <= '0;
         cs_q      <= 1'b0;
         we_q      <= 1'b0;
         wdata_q   <= 8'h00;
         raddr_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         addr_q    <= addr_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         armed_q   <= armed_d;
         flush_q   <= {flush_q[SYNC_STAGES-1:0], 1'b1};
         cs_q      <= cs_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         raddr_q   <= raddr_d;
      end
   end

   assign reg_cs    = cs_q;
   assign reg_we    = we_q;
   assign reg_wdata = wdata_q;
   assign reg_addr  = raddr_q;
   assign spi_miso  = ss_sync ? 1'bz : ((state_q == ST_RDATA) ? tx_q[7] : 1'b0);

endmodule
